// File: rtl/decode_hazard.sv
// Decode-stage hazard unit: load-use / branch-operand stall detection, branch
// resolution with same-cycle redirect, ID/EX slot register and a saturating stall counter.
module decode_hazard #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir,
  input  logic [31:0]      npc,
  input  logic [31:0]      rs1_val,
  input  logic [31:0]      rs2_val,
  input  logic             mem_stall,
  output logic             branch_sig,
  output logic [31:0]      branch_pc,
  output logic             stallF,
  output logic             stallD,
  output logic             ex_valid,
  output logic [31:0]      ex_ir,
  output logic [31:0]      ex_pc,
  output logic [4:0]       ex_rd,
  output logic             ex_is_load,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_OP     = 7'b0110011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic {S_BOOT, S_RUN} state_t;

  state_t           state_q, state_d;
  logic             ex_valid_q, ex_valid_d;
  logic [31:0]      ex_ir_q, ex_ir_d;
  logic [31:0]      ex_pc_q, ex_pc_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             ex_is_load_q, ex_is_load_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2;
  logic        dv, is_jal, is_jalr, is_branch;
  logic        use_rs1, use_rs2, match_rs1, match_rs2;
  logic        load_use, ctrl_hz, hz, taken;
  logic [31:0] imm_i, imm_b, imm_j, target;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign rs1       = ir[19:15];
  assign rs2       = ir[24:20];
  assign dv        = (state_q == S_RUN);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_branch = (opcode == OP_BRANCH);

  assign use_rs1 = (opcode != OP_LUI) && (opcode != OP_AUIPC) && !is_jal;
  assign use_rs2 = is_branch || (opcode == OP_STORE) || (opcode == OP_OP);

  // x0 is never a real producer, so a zero index cannot match.
  assign match_rs1 = use_rs1 && (rs1 != 5'd0) && (ex_rd_q == rs1);
  assign match_rs2 = use_rs2 && (rs2 != 5'd0) && (ex_rd_q == rs2);

  assign load_use = dv && ex_valid_q && ex_is_load_q && (match_rs1 || match_rs2);
  assign ctrl_hz  = dv && (is_branch || is_jalr) && ex_valid_q && (ex_rd_q != 5'd0)
                    && (match_rs1 || match_rs2);
  assign hz       = (load_use || ctrl_hz) && !mem_stall;

  // Reset forces the stall outputs low even if mem_stall is asserted.
  assign stallF = reset && (mem_stall || hz);
  assign stallD = stallF;

  assign imm_i = {{21{ir[31]}}, ir[30:20]};
  assign imm_b = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

  always_comb begin
    taken = 1'b0;
    if (is_jal || is_jalr) begin
      taken = 1'b1;
    end else if (is_branch) begin
      case (funct3)
        3'b000:  taken = (rs1_val == rs2_val);
        3'b001:  taken = (rs1_val != rs2_val);
        3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
        3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
        3'b110:  taken = (rs1_val <  rs2_val);
        3'b111:  taken = (rs1_val >= rs2_val);
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    target = npc + imm_b;
    if (is_jal) begin
      target = npc + imm_j;
    end else if (is_jalr) begin
      target = (rs1_val + imm_i) & 32'hFFFF_FFFE;
    end
  end

  assign branch_sig = dv && taken && !hz && !mem_stall;
  assign branch_pc  = branch_sig ? target : (npc + 32'd4);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // mem_stall freezes EX; a hazard or an invalid decode slot inserts a bubble.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_ir_d      = ex_ir_q;
    ex_pc_d      = ex_pc_q;
    ex_rd_d      = ex_rd_q;
    ex_is_load_d = ex_is_load_q;
    if (!mem_stall) begin
      if (hz || !dv) begin
        ex_valid_d   = 1'b0;
        ex_ir_d      = NOP;
        ex_rd_d      = 5'd0;
        ex_is_load_d = 1'b0;
      end else begin
        ex_valid_d   = dv;
        ex_ir_d      = ir;
        ex_pc_d      = npc;
        ex_rd_d      = ir[11:7];
        ex_is_load_d = (opcode == OP_LOAD);
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hz && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_BOOT;
      ex_valid_q   <= 1'b0;
      ex_ir_q      <= NOP;
      ex_pc_q      <= 32'd0;
      ex_rd_q      <= 5'd0;
      ex_is_load_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ex_valid_q   <= ex_valid_d;
      ex_ir_q      <= ex_ir_d;
      ex_pc_q      <= ex_pc_d;
      ex_rd_q      <= ex_rd_d;
      ex_is_load_q <= ex_is_load_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_ir      = ex_ir_q;
  assign ex_pc      = ex_pc_q;
  assign ex_rd      = ex_rd_q;
  assign ex_is_load = ex_is_load_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_decode_hazard.sv
// Directed bench for decode_hazard: a default-width instance plus a CNT_W=4
// instance sharing the same stimulus for the counter saturation case.
module tb_decode_hazard;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] JAL16   = 32'h0100_006F; // jal  x0,+16
  localparam logic [31:0] LW_X5   = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD_X6  = 32'h0072_8333; // add  x6,x5,x7
  localparam logic [31:0] ADDI_X3 = 32'h0010_0193; // addi x3,x0,1
  localparam logic [31:0] BEQ_M8  = 32'hFE01_8CE3; // beq  x3,x0,-8
  localparam logic [31:0] JALR_X2 = 32'h0041_00E7; // jalr x1,4(x2)
  localparam logic [31:0] JALR_X5 = 32'h0042_80E7; // jalr x1,4(x5)
  localparam logic [31:0] BLT8    = 32'h0020_C463; // blt  x1,x2,+8
  localparam logic [31:0] BLTU8   = 32'h0020_E463; // bltu x1,x2,+8
  localparam logic [31:0] BGEU8   = 32'h0020_F463; // bgeu x1,x2,+8
  localparam logic [31:0] BR_F010 = 32'h0020_A463; // branch, funct3=010

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir, npc, rs1_val, rs2_val;
  logic        mem_stall;

  logic        branch_sig, stallF, stallD, ex_valid, ex_is_load;
  logic [31:0] branch_pc, ex_ir, ex_pc;
  logic [4:0]  ex_rd;
  logic [31:0] stall_cnt;

  logic        branch_sig4, stallF4, stallD4, ex_valid4, ex_is_load4;
  logic [31:0] branch_pc4, ex_ir4, ex_pc4;
  logic [4:0]  ex_rd4;
  logic [3:0]  stall_cnt4;

  int          tests = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  always #5 clk = ~clk;

  decode_hazard dut (
    .clk(clk), .reset(reset), .ir(ir), .npc(npc), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .mem_stall(mem_stall), .branch_sig(branch_sig), .branch_pc(branch_pc),
    .stallF(stallF), .stallD(stallD), .ex_valid(ex_valid), .ex_ir(ex_ir), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
  );

  decode_hazard #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .ir(ir), .npc(npc), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .mem_stall(mem_stall), .branch_sig(branch_sig4), .branch_pc(branch_pc4),
    .stallF(stallF4), .stallD(stallD4), .ex_valid(ex_valid4), .ex_ir(ex_ir4), .ex_pc(ex_pc4),
    .ex_rd(ex_rd4), .ex_is_load(ex_is_load4), .stall_cnt(stall_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                       input logic [31:0] r2, input logic ms);
    ir = i; npc = p; rs1_val = r1; rs2_val = r2; mem_stall = ms;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(JAL16, 32'h8000, 32'd0, 32'd0, 1'b1);
    tick();
    tests++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid: got %b want 0", ex_valid); end
    tests++; if (ex_ir !== NOP) begin errors++; $display("FAIL rst_ex_ir: got %h want %h", ex_ir, NOP); end
    tests++; if (ex_pc !== 32'd0) begin errors++; $display("FAIL rst_ex_pc: got %h want 0", ex_pc); end
    tests++; if (ex_rd !== 5'd0 || ex_is_load !== 1'b0) begin errors++; $display("FAIL rst_rd_load: got %0d/%b want 0/0", ex_rd, ex_is_load); end
    tests++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
    tests++; if (branch_sig !== 1'b0) begin errors++; $display("FAIL rst_branch: got %b want 0", branch_sig); end
    tests++; if (stallF !== 1'b0 || stallD !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b/%b want 0/0", stallF, stallD); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_boot();
    drive(JAL16, 32'h8000, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    tests++; if (branch_sig !== 1'b0) begin errors++; $display("FAIL boot_branch: got %b want 0", branch_sig); end
    tests++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL boot_ex_valid: got %b want 0", ex_valid); end
    tick();
    tests++; if (branch_sig !== 1'b1) begin errors++; $display("FAIL run_jal_sig: got %b want 1", branch_sig); end
    tests++; if (branch_pc !== 32'h8010) begin errors++; $display("FAIL run_jal_pc: got %h want 00008010", branch_pc); end
    tests++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL boot_bubble: got %b want 0", ex_valid); end
    tick();
    tests++; if (ex_valid !== 1'b1 || ex_ir !== JAL16 || ex_pc !== 32'h8000) begin
      errors++; $display("FAIL jal_in_ex: got %b %h %h want 1 %h 00008000", ex_valid, ex_ir, ex_pc, JAL16); end
    drive(NOP, 32'h8004, 32'd0, 32'd0, 1'b0);
    tests++; if (branch_sig !== 1'b0 || branch_pc !== 32'h8008) begin
      errors++; $display("FAIL nop_fallthru: got %b %h want 0 00008008", branch_sig, branch_pc); end
    $display("[TB] test_boot done");
  endtask

  task automatic test_load_use();
    tick();
    drive(LW_X5, 32'h8100, 32'd0, 32'd0, 1'b0);
    tests++; if (stallF !== 1'b0) begin errors++; $display("FAIL lu_pre_stall: got %b want 0", stallF); end
    tick();
    tests++; if (ex_is_load !== 1'b1 || ex_rd !== 5'd5) begin errors++; $display("FAIL lu_lw_ex: got %b %0d want 1 5", ex_is_load, ex_rd); end
    drive(ADD_X6, 32'h8104, 32'd0, 32'd0, 1'b0);
    tests++; if (stallF !== 1'b1 || stallD !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b/%b want 1/1", stallF, stallD); end
    tick();
    exp_cnt = exp_cnt + 1;
    tests++; if (ex_valid !== 1'b0 || ex_ir !== NOP || ex_rd !== 5'd0 || ex_is_load !== 1'b0) begin
      errors++; $display("FAIL lu_bubble: got %b %h %0d %b want 0 %h 0 0", ex_valid, ex_ir, ex_rd, ex_is_load, NOP); end
    tests++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    tests++; if (stallF !== 1'b0) begin errors++; $display("FAIL lu_one_cycle: got %b want 0", stallF); end
    tick();
    tests++; if (ex_valid !== 1'b1 || ex_ir !== ADD_X6 || ex_pc !== 32'h8104 || ex_rd !== 5'd6) begin
      errors++; $display("FAIL lu_add_ex: got %b %h %h %0d want 1 %h 00008104 6", ex_valid, ex_ir, ex_pc, ex_rd, ADD_X6); end
    $display("[TB] test_load_use done");
  endtask

  task automatic test_branch_hazard();
    drive(ADDI_X3, 32'h8200, 32'd0, 32'd0, 1'b0);
    tick();
    drive(BEQ_M8, 32'h8020, 32'd5, 32'd0, 1'b0);
    tests++; if (stallF !== 1'b1) begin errors++; $display("FAIL br_stall: got %b want 1", stallF); end
    tests++; if (branch_sig !== 1'b0) begin errors++; $display("FAIL br_sig_in_stall: got %b want 0", branch_sig); end
    tick();
    exp_cnt = exp_cnt + 1;
    drive(BEQ_M8, 32'h8020, 32'd0, 32'd0, 1'b0);
    tests++; if (stallF !== 1'b0 || branch_sig !== 1'b1) begin errors++; $display("FAIL br_resolve: got %b %b want 0 1", stallF, branch_sig); end
    tests++; if (branch_pc !== 32'h8018) begin errors++; $display("FAIL br_pc: got %h want 00008018", branch_pc); end
    tests++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL br_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    tick();
    $display("[TB] test_branch_hazard done");
  endtask

  task automatic test_jalr_cmp();
    drive(NOP, 32'h8300, 32'd0, 32'd0, 1'b0);
    tick();
    drive(JALR_X2, 32'h8300, 32'h0000_9003, 32'd0, 1'b0);
    tests++; if (branch_sig !== 1'b1 || branch_pc !== 32'h9006) begin errors++; $display("FAIL jalr: got %b %h want 1 00009006", branch_sig, branch_pc); end
    drive(BLT8, 32'h8400, 32'hFFFF_FFFF, 32'd1, 1'b0);
    tests++; if (branch_sig !== 1'b1 || branch_pc !== 32'h8408) begin errors++; $display("FAIL blt: got %b %h want 1 00008408", branch_sig, branch_pc); end
    drive(BLTU8, 32'h8400, 32'hFFFF_FFFF, 32'd1, 1'b0);
    tests++; if (branch_sig !== 1'b0 || branch_pc !== 32'h8404) begin errors++; $display("FAIL bltu: got %b %h want 0 00008404", branch_sig, branch_pc); end
    drive(BGEU8, 32'h8400, 32'hFFFF_FFFF, 32'd1, 1'b0);
    tests++; if (branch_sig !== 1'b1 || branch_pc !== 32'h8408) begin errors++; $display("FAIL bgeu: got %b %h want 1 00008408", branch_sig, branch_pc); end
    drive(BR_F010, 32'h8400, 32'd1, 32'd1, 1'b0);
    tests++; if (branch_sig !== 1'b0 || branch_pc !== 32'h8404) begin errors++; $display("FAIL br_f010: got %b %h want 0 00008404", branch_sig, branch_pc); end
    $display("[TB] test_jalr_cmp done");
  endtask

  task automatic test_mem_stall();
    drive(LW_X5, 32'h8500, 32'd0, 32'd0, 1'b0);
    tick();
    drive(JALR_X5, 32'h8504, 32'h100, 32'd0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tests++; if (stallF !== 1'b1 || branch_sig !== 1'b0) begin errors++; $display("FAIL ms_stall_%0d: got %b %b want 1 0", c, stallF, branch_sig); end
      tests++; if (ex_valid !== 1'b1 || ex_ir !== LW_X5 || ex_pc !== 32'h8500 || ex_rd !== 5'd5 || ex_is_load !== 1'b1) begin
        errors++; $display("FAIL ms_hold_%0d: got %b %h %h %0d %b want 1 %h 00008500 5 1", c, ex_valid, ex_ir, ex_pc, ex_rd, ex_is_load, LW_X5); end
      tests++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL ms_cnt_%0d: got %0d want %0d", c, stall_cnt, exp_cnt); end
      tick();
    end
    drive(JALR_X5, 32'h8504, 32'h100, 32'd0, 1'b0);
    tests++; if (stallF !== 1'b1 || branch_sig !== 1'b0) begin errors++; $display("FAIL ms_hz_after: got %b %b want 1 0", stallF, branch_sig); end
    tick();
    exp_cnt = exp_cnt + 1;
    tests++; if (ex_valid !== 1'b0 || stall_cnt !== exp_cnt) begin errors++; $display("FAIL ms_bubble: got %b %0d want 0 %0d", ex_valid, stall_cnt, exp_cnt); end
    tests++; if (stallF !== 1'b0 || branch_sig !== 1'b1 || branch_pc !== 32'h104) begin
      errors++; $display("FAIL ms_jalr: got %b %b %h want 0 1 00000104", stallF, branch_sig, branch_pc); end
    tick();
    $display("[TB] test_mem_stall done");
  endtask

  task automatic test_reset_mid();
    drive(LW_X5, 32'h8600, 32'd0, 32'd0, 1'b0);
    tick();
    drive(ADD_X6, 32'h8604, 32'd0, 32'd0, 1'b0);
    tests++; if (stallF !== 1'b1) begin errors++; $display("FAIL rm_pre_stall: got %b want 1", stallF); end
    reset = 1'b0;
    #1;
    exp_cnt = 32'd0;
    tests++; if (ex_valid !== 1'b0 || ex_ir !== NOP || ex_pc !== 32'd0 || ex_rd !== 5'd0 || ex_is_load !== 1'b0) begin
      errors++; $display("FAIL rm_ex_clear: got %b %h %h %0d %b want 0 %h 0 0 0", ex_valid, ex_ir, ex_pc, ex_rd, ex_is_load, NOP); end
    tests++; if (stall_cnt !== 32'd0 || stall_cnt4 !== 4'd0) begin errors++; $display("FAIL rm_cnt: got %0d %0d want 0 0", stall_cnt, stall_cnt4); end
    tests++; if (stallF !== 1'b0 || stallD !== 1'b0 || branch_sig !== 1'b0) begin errors++; $display("FAIL rm_outs: got %b %b %b want 0 0 0", stallF, stallD, branch_sig); end
    tick();
    drive(JAL16, 32'h8000, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    tests++; if (branch_sig !== 1'b0) begin errors++; $display("FAIL rm_boot_branch: got %b want 0", branch_sig); end
    tick();
    tests++; if (branch_sig !== 1'b1) begin errors++; $display("FAIL rm_run_branch: got %b want 1", branch_sig); end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_saturation();
    for (int h = 1; h <= 20; h++) begin
      drive(LW_X5, 32'h8700, 32'd0, 32'd0, 1'b0);
      tick();
      drive(ADD_X6, 32'h8704, 32'd0, 32'd0, 1'b0);
      tick();
      exp_cnt = exp_cnt + 1;
      if (h == 14) begin
        tests++; if (stall_cnt4 !== 4'd14) begin errors++; $display("FAIL sat_cnt4_14: got %0d want 14", stall_cnt4); end
      end
    end
    tests++; if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d want 15", stall_cnt4); end
    tests++; if (stall_cnt !== 32'd20 || stall_cnt !== exp_cnt) begin errors++; $display("FAIL sat_cnt32: got %0d want 20", stall_cnt); end
    $display("[TB] test_saturation done");
  endtask

  initial begin
    test_reset();
    test_boot();
    test_load_use();
    test_branch_hazard();
    test_jalr_cmp();
    test_mem_stall();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/decode_hazard.md
DECODE_HAZARD -- requirements
Module: decode_hazard

Interface
REQ-001 Parameter: CNT_W, default 32, width of the stall_cnt performance counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ir  input  32  instruction currently in decode, as produced by the fetch stage.
REQ-005 npc  input  32  byte address of ir.
REQ-006 rs1_val, rs2_val  input  32 each  forwarded operand values for ir[19:15] and ir[24:20].
REQ-007 mem_stall  input  1  downstream memory busy; freezes the front end.
REQ-008 branch_sig  output  1  combinational redirect request to fetch.
REQ-009 branch_pc  output  32  combinational redirect target.
REQ-010 stallF, stallD  output  1 each  combinational hold of the fetch PC and of the decode register.
REQ-011 ex_valid, ex_ir[31:0], ex_pc[31:0], ex_rd[4:0], ex_is_load  output  registered ID/EX slot.
REQ-012 stall_cnt  output  CNT_W  count of hazard-stall cycles, saturating.

Function
REQ-013 FSM states SHALL be BOOT (first cycle after reset release: ir not yet valid) and RUN; BOOT->RUN on the first clock edge; RUN is held until reset.
REQ-014 Decode SHALL be valid (dv) only in RUN; in BOOT there is no hazard, no branch, and a bubble is written to EX.
REQ-015 Use flags: rs1 is used by opcodes other than LUI, AUIPC and JAL; rs2 is used by BRANCH, STORE and OP (0110011); a register index of x0 never counts as a match.
REQ-016 Load-use hazard: dv, ex_valid, ex_is_load, and ex_rd equal to a used, nonzero rs1 or rs2.
REQ-017 Control hazard: dv, ir is BRANCH or JALR, ex_valid, nonzero ex_rd, and ex_rd equal to a used source of ir.
REQ-018 Define hz as load-use hazard OR control hazard, gated by NOT mem_stall.
REQ-019 stallF = stallD = (mem_stall OR hz); both outputs SHALL always be equal.
REQ-020 On mem_stall, all EX registers SHALL hold their values.
REQ-021 On hz, the EX slot SHALL be written as a bubble: ex_valid=0, ex_ir=32'h00000013, ex_rd=0, ex_is_load=0.
REQ-022 Otherwise the EX slot SHALL load decode: ex_valid=dv, ex_ir=ir, ex_pc=npc, ex_rd=ir[11:7], ex_is_load=(opcode==0000011).
REQ-023 Taken conditions:
- JAL (1101111) and JALR (1100111): always taken.
- BRANCH (1100011), by funct3: 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU.
- Other funct3 values under BRANCH: not taken.
REQ-024 branch_sig = dv AND taken AND NOT hz AND NOT mem_stall.
REQ-025 branch_pc targets:
- JAL: npc + sign-extended J-immediate.
- BRANCH: npc + sign-extended B-immediate.
- JALR: (rs1_val + sign-extended I-immediate) with bit 0 cleared.
REQ-026 branch_pc arithmetic SHALL be modulo 2^32.
REQ-027 When branch_sig=0, branch_pc SHALL equal npc+4.
REQ-028 There are no wrong-path instructions: fetch applies the redirect in the same cycle, so no flush is generated.
REQ-029 stall_cnt SHALL increment on each cycle with hz=1 and saturate at all-ones; mem_stall cycles are not counted.
REQ-030 Simultaneous mem_stall and hazard: mem_stall wins; no bubble is written and no count is taken.

Reset
REQ-031 While reset=0, the state SHALL be BOOT.
REQ-032 While reset=0, outputs SHALL be: ex_valid=0, ex_ir=32'h00000013, ex_pc=0, ex_rd=0, ex_is_load=0, stall_cnt=0.
REQ-033 While reset=0, branch_sig=0, stallF=0, stallD=0.
REQ-034 Reset asserted mid-stall or mid-branch SHALL clear all state immediately (asynchronously); the first cycle after release is BOOT.

Verification
REQ-035 Boot: release reset with ir=JAL x0,+16 at npc=8000 -> branch_sig=0 and ex_valid=0 in the BOOT cycle; next RUN cycle with the same ir gives branch_sig=1, branch_pc=8010.
REQ-036 Load-use: EX holds lw x5 (ex_is_load=1, ex_rd=5); decode has add x6,x5,x7 -> stallF=stallD=1 for exactly one cycle, a bubble enters EX, stall_cnt=1, then add x6 enters EX.
REQ-037 Branch operand hazard: EX holds addi x3 (non-load); decode has beq x3,x0,-8 at npc=8020 -> one stall cycle, branch_sig=0 during it; next cycle with rs1_val=0 gives branch_sig=1, branch_pc=8018.
REQ-038 JALR and comparisons: rs1_val=0x00009003, imm=+4 -> branch_pc=0x9006; BLT with 0xFFFFFFFF vs 1 is taken; BLTU with the same operands is not taken.
REQ-039 mem_stall during hazard: assert mem_stall for 3 cycles -> EX holds, stall_cnt does not change, branch_sig=0; after release the hazard stall occurs once.
REQ-040 Saturation: with CNT_W=4, 20 hazard cycles -> stall_cnt=15.
